// File: rtl/rggen_wishbone_pipelined_adapter_pkg.sv
// Shared encodings for the pipelined Wishbone front end:
// bus access codes, status bit index and termination kinds.
package rggen_wishbone_pipelined_adapter_pkg;

  localparam logic [1:0] ACCESS_READ  = 2'b10;
  localparam logic [1:0] ACCESS_WRITE = 2'b11;
  localparam int STATUS_ERROR_BIT = 1;

  typedef enum logic [1:0] {
    TERM_NONE,
    TERM_ACK,
    TERM_ERR,
    TERM_RTY
  } term_e;

  function automatic term_e status_term(
    input logic [1:0] status
  );
    return status[STATUS_ERROR_BIT] ?
      TERM_ERR : TERM_ACK;
  endfunction

  function automatic term_e timeout_term(
    input bit retry
  );
    return retry ? TERM_RTY : TERM_ERR;
  endfunction

endpackage

// File: rtl/rggen_wishbone_pipelined_adapter_if.sv
// Wishbone slave side plus common-bus request side of the adapter.
// Signal names follow the adapter's point of view.
interface rggen_wishbone_pipelined_adapter_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  localparam int SW = BUS_WIDTH / 8;

  logic                     i_wb_cyc;
  logic                     i_wb_stb;
  logic                     o_wb_stall;
  logic [ADDRESS_WIDTH-1:0] i_wb_adr;
  logic                     i_wb_we;
  logic [BUS_WIDTH-1:0]     i_wb_dat;
  logic [SW-1:0]            i_wb_sel;
  logic                     o_wb_ack;
  logic                     o_wb_err;
  logic                     o_wb_rty;
  logic [BUS_WIDTH-1:0]     o_wb_dat;

  logic                     o_bus_valid;
  logic [1:0]               o_bus_access;
  logic [ADDRESS_WIDTH-1:0] o_bus_address;
  logic [BUS_WIDTH-1:0]     o_bus_write_data;
  logic [SW-1:0]            o_bus_strobe;
  logic                     i_bus_ready;
  logic [1:0]               i_bus_status;
  logic [BUS_WIDTH-1:0]     i_bus_read_data;

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_adr,
    input  i_wb_we, i_wb_dat, i_wb_sel,
    output o_wb_stall, o_wb_ack, o_wb_err,
    output o_wb_rty, o_wb_dat,
    output o_bus_valid, o_bus_access,
    output o_bus_address, o_bus_write_data,
    output o_bus_strobe,
    input  i_bus_ready, i_bus_status,
    input  i_bus_read_data
  );

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_adr,
    output i_wb_we, i_wb_dat, i_wb_sel,
    input  o_wb_stall, o_wb_ack, o_wb_err,
    input  o_wb_rty, o_wb_dat,
    input  o_bus_valid, o_bus_access,
    input  o_bus_address, o_bus_write_data,
    input  o_bus_strobe,
    output i_bus_ready, i_bus_status,
    output i_bus_read_data
  );

endinterface

// File: rtl/rggen_wishbone_request_fifo.sv
// In-order request buffer; flush_tail keeps only the head entry
// (or nothing when the head pops in the same cycle).
module rggen_wishbone_request_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush_tail,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count,
  output logic             o_full
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd;
  logic [PW-1:0]    r_wr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic [PW-1:0]    w_rd_nx;
  logic [PW-1:0]    w_wr_nx;
  logic [CW-1:0]    w_count_nx;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ?
      '0 : p + PW'(1);
  endfunction

  always_comb begin
    w_rd_nx    = r_rd;
    w_wr_nx    = r_wr;
    w_count_nx = r_count;
    if (i_flush_tail) begin
      if (i_pop) begin
        w_rd_nx    = inc(r_rd);
        w_wr_nx    = inc(r_rd);
        w_count_nx = '0;
      end else if (r_count != '0) begin
        w_wr_nx    = inc(r_rd);
        w_count_nx = CW'(1);
      end
    end else begin
      if (i_push) w_wr_nx = inc(r_wr);
      if (i_pop)  w_rd_nx = inc(r_rd);
      if (i_push && !i_pop)
        w_count_nx = r_count + CW'(1);
      else if (!i_push && i_pop)
        w_count_nx = r_count - CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      r_rd    <= w_rd_nx;
      r_wr    <= w_wr_nx;
      r_count <= w_count_nx;
      r_full  <= (w_count_nx == CW'(DEPTH));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush_tail)
      r_mem[r_wr] <= i_data;
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;
  assign o_full  = r_full;

endmodule

// File: rtl/rggen_wishbone_pipelined_adapter.sv
// Pipelined Wishbone B4 slave front end for RgGen register blocks:
// queues requests, issues them in order, adds watchdog and CYC abort.
module rggen_wishbone_pipelined_adapter
  import rggen_wishbone_pipelined_adapter_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int REQUEST_DEPTH  = 2,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TIMEOUT_RETRY  = 0
)(
  input logic i_clk,
  input logic i_rst,
  rggen_wishbone_pipelined_adapter_if.slave bus_if
);
  localparam int SW = BUS_WIDTH / 8;
  localparam int EW = ADDRESS_WIDTH + 1 + BUS_WIDTH + SW;
  localparam int CW = $clog2(REQUEST_DEPTH + 1);
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic                     w_push;
  logic                     w_pop;
  logic                     w_done;
  logic                     w_timeout;
  logic                     w_abort;
  logic                     w_mute;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_valid;
  logic [CW-1:0]            w_count;
  logic [EW-1:0]            w_head;
  logic [ADDRESS_WIDTH-1:0] w_adr;
  logic                     w_we;
  logic [BUS_WIDTH-1:0]     w_dat;
  logic [SW-1:0]            w_sel;
  logic                     r_pend;
  logic                     r_orphan;
  term_e                    r_term;
  logic [BUS_WIDTH-1:0]     r_dat;

  rggen_wishbone_request_fifo #(
    .DEPTH (REQUEST_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_flush_tail (w_abort),
    .i_data       ({bus_if.i_wb_adr, bus_if.i_wb_we,
                    bus_if.i_wb_dat, bus_if.i_wb_sel}),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_full       (w_full)
  );

  assign {w_adr, w_we, w_dat, w_sel} = w_head;
  assign w_empty = (w_count == '0);
  assign w_push  = bus_if.i_wb_cyc & bus_if.i_wb_stb & ~w_full;
  assign w_abort = ~bus_if.i_wb_cyc & (~w_empty | r_pend);
  assign w_valid = ~w_empty & ~r_pend;
  assign w_done  = w_valid & bus_if.i_bus_ready;
  assign w_pop   = w_done | w_timeout;
  // A head that outlived its CYC still runs to completion, silently.
  assign w_mute  = r_orphan | w_abort;

  if (TIMEOUT_CYCLES > 0) begin : g_wdog
    logic [TW-1:0] r_wdog;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
        r_wdog <= '0;
      else if (w_pop)
        r_wdog <= '0;
      else if (w_valid && !bus_if.i_bus_ready)
        r_wdog <= r_wdog + TW'(1);
    end

    // Ready on the expiry cycle takes priority via w_done.
    assign w_timeout = w_valid & ~bus_if.i_bus_ready &
      (r_wdog == TW'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_wdog
    assign w_timeout = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend   <= 1'b0;
      r_orphan <= 1'b0;
      r_term   <= TERM_NONE;
      r_dat    <= '0;
    end else begin
      r_pend <= w_pop;
      if (w_pop)
        r_orphan <= 1'b0;
      else if (w_abort && !w_empty)
        r_orphan <= 1'b1;
      if (!w_pop || w_mute)
        r_term <= TERM_NONE;
      else if (w_done)
        r_term <= status_term(bus_if.i_bus_status);
      else
        r_term <= timeout_term(TIMEOUT_RETRY != 0);
      if (w_done)
        r_dat <= bus_if.i_bus_read_data;
      else if (w_timeout)
        r_dat <= '0;
    end
  end

  assign bus_if.o_wb_stall = w_full;
  assign bus_if.o_wb_ack =
    bus_if.i_wb_cyc & (r_term == TERM_ACK);
  assign bus_if.o_wb_err =
    bus_if.i_wb_cyc & (r_term == TERM_ERR);
  assign bus_if.o_wb_rty =
    bus_if.i_wb_cyc & (r_term == TERM_RTY);
  assign bus_if.o_wb_dat = r_dat;

  assign bus_if.o_bus_valid = w_valid;
  assign bus_if.o_bus_access = w_empty ? 2'b00 :
    (w_we ? ACCESS_WRITE : ACCESS_READ);
  assign bus_if.o_bus_address    = w_empty ? '0 : w_adr;
  assign bus_if.o_bus_write_data = w_empty ? '0 : w_dat;
  assign bus_if.o_bus_strobe     = w_empty ? '0 : w_sel;

endmodule
